// File: rtl/collision_arbiter.sv
// rtl/collision_arbiter.sv - per-frame player/object collision detection with event reporting
module collision_arbiter #(
  parameter int NUM_OBJ = 16,
  localparam int ID_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               drawing_request_player,
  input  logic [NUM_OBJ-1:0] drawing_request_obj,
  input  logic [NUM_OBJ-1:0] obj_enable,
  input  logic               event_ack,
  output logic [NUM_OBJ-1:0] coll_now,
  output logic [NUM_OBJ-1:0] first_hit,
  output logic [NUM_OBJ-1:0] frame_hits,
  output logic               event_valid,
  output logic [ID_W-1:0]    event_id
);

  logic [NUM_OBJ-1:0] acc;
  logic [NUM_OBJ-1:0] pending;
  logic [NUM_OBJ-1:0] acc_prior;
  logic [NUM_OBJ-1:0] pend_set;
  logic [NUM_OBJ-1:0] ack_clr;
  logic [NUM_OBJ-1:0] pending_next;

  assign coll_now = {NUM_OBJ{drawing_request_player}} & drawing_request_obj & obj_enable;

  // A pixel coincident with startOfFrame belongs to the new frame, so the old acc is ignored
  assign acc_prior = startOfFrame ? '0 : acc;

  // Only objects that did not collide in the previous frame raise a new event
  assign pend_set = startOfFrame ? (acc & ~frame_hits) : '0;
  assign ack_clr  = (event_valid && event_ack) ? (NUM_OBJ'(1) << event_id) : '0;

  // Set beats ack-clear; disable beats everything
  assign pending_next = ((pending & ~ack_clr) | pend_set) & obj_enable;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc        <= '0;
      first_hit  <= '0;
      frame_hits <= '0;
      pending    <= '0;
    end else begin
      acc       <= acc_prior | coll_now;
      first_hit <= coll_now & ~acc_prior;
      pending   <= pending_next;
      if (startOfFrame) begin
        frame_hits <= acc;
      end
    end
  end

  assign event_valid = |pending;

  always_comb begin
    event_id = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        event_id = ID_W'(i);
      end
    end
  end

endmodule
